// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   Memory-mapped bank of NrChannels independent up-counters. Each channel has
//   CTRL (EN, AUTO, IRQ_EN, PRESCALE), COUNT, COMPARE and W1C STATUS
//   (MATCH, OVF) registers and a level interrupt MATCH & IRQ_EN.
//
//   Address map: channel = addr_i[7:4], register = addr_i[3:2]
//     0x0 CTRL   [0] EN, [1] AUTO, [2] IRQ_EN, [31:16] PRESCALE
//     0x4 COUNT
//     0x8 COMPARE
//     0xC STATUS [0] MATCH, [1] OVF (write 1 to clear)
//   Channels >= NrChannels are unmapped (read 0, writes dropped).
//
//   Build option: define TIMER_BANK_PRESCALER_EN to get a 16-bit prescaler per
//   channel. Without it every enabled cycle is a tick and CTRL[31:16] reads 0.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   req_i      bus request, one cycle per access
//   we_i       1 = write, 0 = read
//   addr_i     byte address (only [7:0] decoded)
//   wdata_i    write data
//   rdata_o    registered read data, holds until the next read
//   irq_o      per-channel interrupt (MATCH & IRQ_EN)
//   irq_any_o  OR of irq_o
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int NrChannels = 4,
    parameter int CntWidth   = 32,
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [AddrWidth-1:0]  addr_i,
    input  logic [DataWidth-1:0]  wdata_i,
    output logic [DataWidth-1:0]  rdata_o,
    output logic [NrChannels-1:0] irq_o,
    output logic                  irq_any_o
);

    logic [3:0]                           w_ch;
    logic [1:0]                           w_reg;
    logic                                 w_wr;
    logic                                 w_rd;
    logic [NrChannels-1:0][31:0]          w_ctrl_rd;
    logic [NrChannels-1:0][CntWidth-1:0]  w_cnt_rd;
    logic [NrChannels-1:0][CntWidth-1:0]  w_cmp_rd;
    logic [NrChannels-1:0][1:0]           w_sts_rd;
    logic [DataWidth-1:0]                 w_rword;
    logic [DataWidth-1:0]                 r_rdata;
    logic                                 w_unused;

    assign w_ch  = addr_i[7:4];
    assign w_reg = addr_i[3:2];
    assign w_wr  = req_i & we_i;
    assign w_rd  = req_i & ~we_i;

    // Only part of the address and, depending on widths, of the data is used.
    assign w_unused = ^{addr_i, wdata_i};

    for (genvar g = 0; g < NrChannels; g++) begin : g_ch
        logic                r_en;
        logic                r_auto;
        logic                r_ie;
        logic [CntWidth-1:0] r_count;
        logic [CntWidth-1:0] r_cmp;
        logic                r_match;
        logic                r_ovf;
        logic                w_sel;
        logic                w_wr_ctrl;
        logic                w_wr_cnt;
        logic                w_wr_cmp;
        logic                w_wr_sts;
        logic                w_tick;
        logic                w_tick_eff;
        logic                w_hit;
        logic                w_set_m;
        logic                w_set_o;
        logic [15:0]         w_ps_rd;

        assign w_sel     = (w_ch == 4'(g));
        assign w_wr_ctrl = w_wr & w_sel & (w_reg == 2'd0);
        assign w_wr_cnt  = w_wr & w_sel & (w_reg == 2'd1);
        assign w_wr_cmp  = w_wr & w_sel & (w_reg == 2'd2);
        assign w_wr_sts  = w_wr & w_sel & (w_reg == 2'd3);

`ifdef TIMER_BANK_PRESCALER_EN
        logic [15:0] r_ps;
        logic [15:0] r_pc;

        assign w_tick  = r_en & (r_pc == r_ps);
        assign w_ps_rd = r_ps;

        // Prescaler restarts on any CTRL/COUNT write so a new setting always
        // begins a full period; held at 0 while disabled.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_ps <= '0;
                r_pc <= '0;
            end else begin
                if (w_wr_ctrl)
                    r_ps <= wdata_i[31:16];
                if (w_wr_ctrl | w_wr_cnt | ~r_en | w_tick)
                    r_pc <= '0;
                else
                    r_pc <= r_pc + 16'd1;
            end
        end
`else
        assign w_tick  = r_en;
        assign w_ps_rd = '0;
`endif

        // A COUNT write on a tick edge wins outright: no match/overflow and
        // no one-shot disable are evaluated.
        assign w_tick_eff = w_tick & ~w_wr_cnt;
        assign w_hit      = (r_count == r_cmp);
        assign w_set_m    = w_tick_eff & w_hit;
        assign w_set_o    = w_tick_eff & ~w_hit & (&r_count);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_en    <= 1'b0;
                r_auto  <= 1'b0;
                r_ie    <= 1'b0;
                r_count <= '0;
                r_cmp   <= '0;
                r_match <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                // Tick uses pre-write CTRL/COMPARE; writes below override.
                if (w_tick_eff) begin
                    if (w_hit) begin
                        if (r_auto)
                            r_count <= '0;
                        else
                            r_en <= 1'b0;
                    end else begin
                        r_count <= r_count + CntWidth'(1);
                    end
                end
                if (w_wr_ctrl) begin
                    r_en   <= wdata_i[0];
                    r_auto <= wdata_i[1];
                    r_ie   <= wdata_i[2];
                end
                if (w_wr_cnt)
                    r_count <= wdata_i[CntWidth-1:0];
                if (w_wr_cmp)
                    r_cmp <= wdata_i[CntWidth-1:0];
                // Set beats a same-edge W1C.
                r_match <= (r_match & ~(w_wr_sts & wdata_i[0])) | w_set_m;
                r_ovf   <= (r_ovf   & ~(w_wr_sts & wdata_i[1])) | w_set_o;
            end
        end

        assign w_ctrl_rd[g] = {w_ps_rd, 13'b0, r_ie, r_auto, r_en};
        assign w_cnt_rd[g]  = r_count;
        assign w_cmp_rd[g]  = r_cmp;
        assign w_sts_rd[g]  = {r_ovf, r_match};
        assign irq_o[g]     = r_match & r_ie;
    end

    // Loop over mapped channels so an unmapped channel number simply falls
    // through to the zero default.
    always_comb begin
        w_rword = '0;
        for (int c = 0; c < NrChannels; c++) begin
            if (w_ch == 4'(c)) begin
                case (w_reg)
                    2'd0:    w_rword = DataWidth'(w_ctrl_rd[c]);
                    2'd1:    w_rword = DataWidth'(w_cnt_rd[c]);
                    2'd2:    w_rword = DataWidth'(w_cmp_rd[c]);
                    default: w_rword = DataWidth'(w_sts_rd[c]);
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_rdata <= '0;
        else if (w_rd)
            r_rdata <= w_rword;
    end

    assign rdata_o   = r_rdata;
    assign irq_any_o = |irq_o;

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel memory-mapped timer peripheral: the parametrised successor to the single-channel SoC timer, sitting as a bus device slave beside the console and data RAM. It provides `NrChannels` independent up-counters. Each channel has a compare register, one-shot or auto-reload mode, match and overflow status, and a maskable interrupt. Per-channel and combined interrupt outputs are intended for the core's future interrupt input.

## Interface
- `NrChannels`, 4, number of timer channels, 1..16
- `CntWidth`, 32, counter/compare width, 8..32; registers are zero-extended to `DataWidth` on read
- `DataWidth`, 32, bus data width
- `AddrWidth`, 32, bus address width
- `clk_i` in 1: clock
- `rst_i` in 1: synchronous, active-high reset
- `req_i` in 1: device request from bus, one cycle per access
- `we_i` in 1: 1 = write, 0 = read
- `addr_i` in `AddrWidth`: byte address; only `addr_i[7:0]` is decoded
- `wdata_i` in `DataWidth`: write data
- `rdata_o` out `DataWidth`: read data, registered
- `irq_o` out `NrChannels`: per-channel interrupt, level
- `irq_any_o` out 1: OR of `irq_o`

## Operation
- **Address decode**
  - Channel = `addr_i[7:4]`; register = `addr_i[3:2]`; `addr_i[1:0]` ignored.
  - Channel ≥ `NrChannels` is unmapped: reads return 0, writes are ignored.
- **CTRL (0x0)**
  - [0] EN
  - [1] AUTO: 1 = reload to 0 on match, 0 = one-shot
  - [2] IRQ_EN
  - [31:16] PRESCALE
  - All other bits read 0.
- **COUNT (0x4)**: current count, read/write.
- **COMPARE (0x8)**: match value, read/write.
- **STATUS (0xC)**
  - [0] MATCH, [1] OVF; write 1 to clear.
- **Tick**
  - With EN=1, a channel ticks when its prescaler reaches PRESCALE, and the prescaler returns to 0.
  - With EN=0 the prescaler is held at 0.
- **On tick**
  - If COUNT == COMPARE: set MATCH. If AUTO=1, COUNT←0. If AUTO=0, EN←0 and COUNT holds.
  - Otherwise COUNT←COUNT+1. Wrap from 2^`CntWidth`−1 to 0 sets OVF.
- **Interrupts**: `irq_o[i]` = MATCH[i] & IRQ_EN[i].
- **Write side effects**
  - A write to COUNT, or to CTRL, clears that channel's prescaler.
  - Writing EN 0→1 does not alter COUNT.

## Timing
- **Reset**: all registers are 0; `rdata_o`=0, `irq_o`=0, `irq_any_o`=0.
- **Writes** take effect at the clock edge where `req_i`&`we_i`; the new value is visible to reads and to tick logic from the next cycle.
- **Reads**: `rdata_o` is valid in the cycle after `req_i`&!`we_i`. It holds its value until the next read, and is not updated on writes.
- **Count rate**: PRESCALE=p gives one tick every p+1 cycles. With p=0 there is one tick per cycle, and the first tick comes 1 cycle after EN is written.
- **Match to interrupt**: MATCH and `irq_o` rise in the cycle after the tick edge, i.e. registered, 0 extra latency.
- **Simultaneous events** (same edge)
  - COUNT write vs. tick: the write wins; no match or OVF is evaluated.
  - CTRL write vs. tick: the tick is evaluated with the pre-write CTRL; CTRL takes the written value. A one-shot match clearing EN loses to a write of EN=1.
  - STATUS W1C vs. set of the same bit: set wins.
  - COMPARE write vs. tick: the tick compares against the old COMPARE.
- **Reset during operation**: immediate at the next edge, regardless of an in-flight read. `rdata_o` is 0 after reset.

## Configuration
- **`TIMER_BANK_PRESCALER_EN`** defined: per-channel 16-bit prescaler exactly as above.
- **Undefined**:
  - No prescaler registers are synthesised.
  - Every enabled cycle is a tick.
  - CTRL[31:16] ignores writes and reads 0.

## Test plan
- **Reset values**: after reset, read every register of channels 0..3 → all 0; `irq_o`=0.
- **Auto-reload**: ch0, COMPARE=3, CTRL=0x7 (EN, AUTO, IRQ_EN, p=0) → COUNT sequence 1,2,3,0,1…. MATCH and `irq_o[0]` rise one cycle after COUNT=3 is ticked. W1C 0x1 to STATUS drops `irq_o[0]` the next cycle; the match repeats every 4 ticks.
- **One-shot with prescaler**: ch1, COMPARE=2, CTRL=0x0002_0005 (EN, IRQ_EN, p=2) → COUNT increments every 3 cycles; after the match, CTRL.EN reads 0 and COUNT holds at 2. Without the macro, increments happen every cycle.
- **Overflow**: `CntWidth`=8, ch2 COUNT=0xFE, COMPARE=0x10, EN → COUNT goes 0xFF, then 0x00 with STATUS=0x2; `irq_o` stays 0.
- **Write/tick collisions**: on a tick edge of ch0, write COUNT=0x40 → COUNT reads 0x40 with no increment. W1C of MATCH on the match edge → MATCH stays 1.
- **Unmapped channel**: `NrChannels`=4, write/read at offset 0x50 → reads 0, other channels unchanged; `irq_any_o` equals the OR of per-channel interrupts throughout.
